// File: rtl/axis_shim_pkg.sv
// Shared types and helpers for the multi-channel AXI-Stream to NoC injection shim.
package axis_shim_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_shim_beat_fifo.sv
// Per-channel beat FIFO: registered wrap-bit pointers, combinational head read.
module axis_shim_beat_fifo
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_wr, do_rd;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + (AW+1)'(1);
    if (do_rd) rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/axis_multi_serializer_shim_in.sv
// Buffers N AXI-Stream inputs, arbitrates packet-atomically round-robin and
// serializes the granted beat into credit-controlled NoC flits.
//   state   | meaning
//   IDLE    | pick next non-empty channel from prio_q, latch its dest
//   SEND    | stream flits of the locked channel until its tail flit
module axis_multi_serializer_shim_in
  import axis_shim_pkg::*;
#(
  parameter  int NUM_CHANNELS         = 4,
  parameter  int TID_WIDTH            = 2,
  parameter  int TDEST_WIDTH          = 4,
  parameter  int TDATA_WIDTH          = 512,
  parameter  int SERIALIZATION_FACTOR = 4,
  parameter  int IN_BUFFER_DEPTH      = 2,
  parameter  int FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH
)
(
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic [NUM_CHANNELS-1:0] axis_in_tvalid,
  output logic [NUM_CHANNELS-1:0] axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_in_tdata [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] axis_in_tlast,
  input  logic [TID_WIDTH-1:0]    axis_in_tid   [NUM_CHANNELS],
  input  logic [TDEST_WIDTH-1:0]  axis_in_tdest [NUM_CHANNELS],
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic                    credit_overflow
);

  localparam int GW  = cnt_width(NUM_CHANNELS);
  localparam int FCW = cnt_width(SERIALIZATION_FACTOR);
  localparam int CW  = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [FCW-1:0] LAST_SLICE = FCW'(SERIALIZATION_FACTOR - 1);
  localparam logic [GW-1:0]  LAST_CH    = GW'(NUM_CHANNELS - 1);
  localparam logic [CW-1:0]  CRED_MAX   = CW'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t                   head [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_e                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           prio_q, prio_d;
  logic [FCW-1:0]          flit_cnt_q, flit_cnt_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [FLIT_WIDTH-1:0]   data_q, data_d;
  logic                    send_q, send_d;
  logic                    tail_q, tail_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic                    ovf_q, ovf_d;

  logic                    emit, pop_en;
  logic                    arb_found;
  logic [GW-1:0]           arb_idx, arb_cand_g;
  int                      arb_cand;
  beat_t                   gnt_head;
  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] gnt_slices;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    beat_t wr_beat;

    assign wr_beat           = '{data: axis_in_tdata[c], last: axis_in_tlast[c],
                                 id: axis_in_tid[c], dest: axis_in_tdest[c]};
    assign axis_in_tready[c] = ~fifo_full[c] & ~rst_noc_sync;
    assign fifo_push[c]      = axis_in_tvalid[c] & axis_in_tready[c];
    assign fifo_pop[c]       = pop_en & (grant_q == GW'(c));

    axis_shim_beat_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (IN_BUFFER_DEPTH)
    ) u_fifo (
      .clk_i     (clk_noc),
      .rst_i     (rst_noc_sync),
      .wr_en_i   (fifo_push[c]),
      .wr_data_i (wr_beat),
      .rd_en_i   (fifo_pop[c]),
      .rd_data_o (head[c]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c])
    );
  end

  // Walk offsets high to low so the lowest offset from prio_q wins last.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_cand   = 0;
    arb_cand_g = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      arb_cand   = (int'(prio_q) + i) % NUM_CHANNELS;
      arb_cand_g = GW'(arb_cand);
      if (!fifo_empty[arb_cand_g]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand_g;
      end
    end
  end

  assign gnt_head   = head[grant_q];
  assign gnt_slices = gnt_head.data;
  assign emit       = (state_q == ST_SEND) && !fifo_empty[grant_q] && (credit_q != '0);
  assign pop_en     = emit && (flit_cnt_q == LAST_SLICE);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    flit_cnt_d = flit_cnt_q;
    dest_d     = dest_q;
    data_d     = data_q;
    send_d     = 1'b0;
    tail_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d    = arb_idx;
          dest_d     = {head[arb_idx].id, head[arb_idx].dest};
          flit_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (emit) begin
          send_d = 1'b1;
          data_d = gnt_slices[flit_cnt_q];
          if (pop_en) begin
            flit_cnt_d = '0;
            if (gnt_head.last) begin
              tail_d  = 1'b1;
              prio_d  = (grant_q == LAST_CH) ? '0 : grant_q + GW'(1);
              state_d = ST_IDLE;
            end
          end else begin
            flit_cnt_d = flit_cnt_q + FCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    if (emit && !credit_in) begin
      credit_d = credit_q - CW'(1);
    end else if (!emit && credit_in) begin
      if (credit_q == CRED_MAX) ovf_d = 1'b1;
      else                      credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      prio_q     <= '0;
      flit_cnt_q <= '0;
      dest_q     <= '0;
      data_q     <= '0;
      send_q     <= 1'b0;
      tail_q     <= 1'b0;
      credit_q   <= CRED_MAX;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      flit_cnt_q <= flit_cnt_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      send_q     <= send_d;
      tail_q     <= tail_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out        = data_q;
  assign dest_out        = dest_q;
  assign is_tail_out     = tail_q;
  assign send_out        = send_q;
  assign credit_overflow = ovf_q;

endmodule
